camera_init_seq: RTL and testbench

- Register-table sequencer that sits directly upstream of the I2C register controller in the camera_init path.
- Walks an external configuration table of {addr16, data8} entries and issues one register write per entry through the controller's wrreg_req / RW_Done handshake.
- Handles power-up delay, in-table delay markers and NACK bookkeeping.
- Raises init_done when the whole table has been written, which gates the DVP capture path.

---
 rtl/camera_init_pkg.sv | 44 ++++
 rtl/camera_init_ms_timer.sv | 38 +++
 rtl/camera_init_seq.sv | 165 ++++++++++++++++
 tb/tb_camera_init_seq.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_init_pkg.sv
// Shared encodings for the camera register-table sequencer:
// one-hot states, delay marker, retry limit and table entry fields.
package camera_init_pkg;

    localparam int unsigned I_IDLE   = 0;
    localparam int unsigned I_PWRUP  = 1;
    localparam int unsigned I_FETCH  = 2;
    localparam int unsigned I_DECODE = 3;
    localparam int unsigned I_ISSUE  = 4;
    localparam int unsigned I_WAIT   = 5;
    localparam int unsigned I_TDLY   = 6;
    localparam int unsigned I_NEXT   = 7;
    localparam int unsigned I_DONE   = 8;

    typedef logic [8:0] state_t;

    localparam state_t ST_IDLE   = state_t'(1 << I_IDLE);
    localparam state_t ST_PWRUP  = state_t'(1 << I_PWRUP);
    localparam state_t ST_FETCH  = state_t'(1 << I_FETCH);
    localparam state_t ST_DECODE = state_t'(1 << I_DECODE);
    localparam state_t ST_ISSUE  = state_t'(1 << I_ISSUE);
    localparam state_t ST_WAIT   = state_t'(1 << I_WAIT);
    localparam state_t ST_TDLY   = state_t'(1 << I_TDLY);
    localparam state_t ST_NEXT   = state_t'(1 << I_NEXT);
    localparam state_t ST_DONE   = state_t'(1 << I_DONE);

    localparam logic [15:0] DLY_MARKER = 16'hFFFF;
    localparam logic [1:0]  MAX_RETRY  = 2'd3;

    // Table entry layout: {addr[15:0], data[7:0]}
    localparam int unsigned ADDR_HI = 23;
    localparam int unsigned ADDR_LO = 8;
    localparam int unsigned DATA_HI = 7;
    localparam int unsigned DATA_LO = 0;

    function automatic logic [15:0] entry_addr(input logic [23:0] e);
        return e[ADDR_HI:ADDR_LO];
    endfunction

    function automatic logic [7:0] entry_data(input logic [23:0] e);
        return e[DATA_HI:DATA_LO];
    endfunction

endpackage

// File: rtl/camera_init_ms_timer.sv
// Millisecond down-counter shared by the power-up wait and in-table delays.
// Comes out of reset already loaded with the power-up delay.
module camera_init_ms_timer #(
    parameter int unsigned CYC_PER_MS = 50_000,
    parameter int unsigned RST_MS     = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] ms,
    output logic        expired
);

    localparam logic [31:0] CPM     = 32'(CYC_PER_MS);
    localparam logic [31:0] RST_CNT = 32'(RST_MS * CYC_PER_MS);

    logic [31:0] cnt;
    logic        active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= RST_CNT;
            active <= 1'b1;
        end else if (load) begin
            cnt    <= {16'd0, ms} * CPM;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0)
                active <= 1'b0;
            else
                cnt <= cnt - 32'd1;
        end
    end

    // Single-cycle pulse: active drops on the cycle after reaching zero
    assign expired = active && (cnt == '0);

endmodule

// File: rtl/camera_init_seq.sv
// Camera register-table sequencer feeding the I2C register controller.
// Define CAMERA_INIT_NACK_RETRY_EN to re-issue NACKed entries up to 3 times.
module camera_init_seq
    import camera_init_pkg::*;
#(
    parameter int unsigned SYS_CLOCK = 50_000_000,
    parameter int unsigned TABLE_LEN = 252,
    parameter logic [7:0]  DEVICE_ID = 8'h78,
    parameter logic        ADDR_MODE = 1'b1,
    parameter int unsigned PWRUP_MS  = 20,
    parameter logic [31:0] INTER_DLY = 32'd500
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start,
    output logic [9:0]  lut_index,
    input  logic [23:0] lut_data,
    output logic        wrreg_req,
    output logic        rdreg_req,
    output logic [15:0] addr,
    output logic        addr_mode,
    output logic [7:0]  wrdata,
    output logic [7:0]  device_id,
    output logic [31:0] dly_cnt_max,
    input  logic        RW_Done,
    input  logic        ack,
    output logic        init_busy,
    output logic        init_done,
    output logic [7:0]  nack_cnt,
    output logic        nack_flag
);

    localparam logic [9:0]  LAST_IDX   = 10'(TABLE_LEN - 1);
    localparam int unsigned CYC_PER_MS = SYS_CLOCK / 1000;

    state_t      state;
    state_t      state_nxt;
    logic        timer_load;
    logic [15:0] timer_ms;
    logic        timer_exp;
    logic        is_marker;
    logic        last_entry;
    logic        start_ok;
    logic        retry_go;
    logic        nack_hit;

    assign is_marker  = entry_addr(lut_data) == DLY_MARKER;
    assign last_entry = lut_index == LAST_IDX;
    assign start_ok   = start && (state[I_IDLE] || state[I_DONE]);
    assign nack_hit   = state[I_WAIT] && RW_Done && ack && !retry_go;

    assign rdreg_req   = 1'b0;
    assign addr_mode   = ADDR_MODE;
    assign device_id   = DEVICE_ID;
    assign dly_cnt_max = INTER_DLY;

`ifdef CAMERA_INIT_NACK_RETRY_EN
    logic [1:0] retry;

    assign retry_go = ack && (retry != MAX_RETRY);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            retry <= '0;
        else if (state[I_NEXT])
            retry <= '0;
        else if (state[I_WAIT] && RW_Done && retry_go)
            retry <= retry + 2'd1;
    end
`else
    assign retry_go = 1'b0;
`endif

    camera_init_ms_timer #(
        .CYC_PER_MS(CYC_PER_MS),
        .RST_MS    (PWRUP_MS)
    ) u_timer (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .load   (timer_load),
        .ms     (timer_ms),
        .expired(timer_exp)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= ST_PWRUP;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            state[I_IDLE], state[I_DONE]:
                if (start) state_nxt = ST_PWRUP;
            state[I_PWRUP]:
                if (timer_exp) state_nxt = ST_FETCH;
            state[I_FETCH]:
                state_nxt = ST_DECODE;
            state[I_DECODE]:
                state_nxt = is_marker ? ST_TDLY : ST_ISSUE;
            state[I_ISSUE]:
                state_nxt = ST_WAIT;
            state[I_WAIT]:
                if (RW_Done) state_nxt = retry_go ? ST_ISSUE : ST_NEXT;
            state[I_TDLY]:
                if (timer_exp) state_nxt = ST_NEXT;
            state[I_NEXT]:
                state_nxt = last_entry ? ST_DONE : ST_FETCH;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wrreg_req  = 1'b0;
        timer_load = 1'b0;
        timer_ms   = 16'(PWRUP_MS);
        unique case (1'b1)
            state[I_IDLE], state[I_DONE]:
                timer_load = start;
            state[I_DECODE]: begin
                timer_load = is_marker;
                timer_ms   = {8'h00, entry_data(lut_data)};
            end
            state[I_ISSUE]:
                wrreg_req = 1'b1;
            default: ;
        endcase
    end

    // Status flags follow the next state so they are 0 while in reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lut_index <= '0;
            addr      <= '0;
            wrdata    <= '0;
            nack_cnt  <= '0;
            nack_flag <= 1'b0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
        end else begin
            init_busy <= !(state_nxt[I_IDLE] || state_nxt[I_DONE]);
            init_done <= state_nxt[I_DONE];
            if (start_ok) begin
                lut_index <= '0;
                nack_cnt  <= '0;
                nack_flag <= 1'b0;
            end
            if (state[I_DECODE]) begin
                addr   <= entry_addr(lut_data);
                wrdata <= entry_data(lut_data);
            end
            if (state[I_NEXT] && !last_entry)
                lut_index <= lut_index + 10'd1;
            if (nack_hit) begin
                nack_flag <= 1'b1;
                if (nack_cnt != 8'hFF)
                    nack_cnt <= nack_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_camera_init_seq.sv
// Self-checking bench for camera_init_seq: registered ROM, I2C controller
// model with random latency and NACK injection, and a write-list reference.
module tb_camera_init_seq;

    localparam int TL = 6;
`ifdef CAMERA_INIT_NACK_RETRY_EN
    localparam int ATT = 4;
`else
    localparam int ATT = 1;
`endif

    typedef struct packed {
        logic [TL-1:0][23:0] ent;
        logic [TL-1:0]       nk;
        logic [7:0]          wr_plain;
        logic [7:0]          wr_retry;
        logic [7:0]          nacks;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  lut_index;
    logic [23:0] lut_data;
    logic        wrreg_req;
    logic        rdreg_req;
    logic [15:0] addr;
    logic        addr_mode;
    logic [7:0]  wrdata;
    logic [7:0]  device_id;
    logic [31:0] dly_cnt_max;
    logic        rw_done;
    logic        ack;
    logic        spur_done;
    logic        spur_ack;
    logic        init_busy;
    logic        init_done;
    logic [7:0]  nack_cnt;
    logic        nack_flag;

    logic [23:0] rom [1024];
    logic [TL-1:0] nk_cur;
    vec_t        vecs [3];

    logic [23:0] log_q [$];
    logic [23:0] exp_q [$];
    int          wr_cyc_q [$];
    int          done_cyc_q [$];
    int          exp_nack;
    int          hs_err;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    camera_init_seq #(
        .SYS_CLOCK(1_000_000),
        .TABLE_LEN(TL),
        .DEVICE_ID(8'h78),
        .ADDR_MODE(1'b1),
        .PWRUP_MS (1),
        .INTER_DLY(32'd500)
    ) dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .start      (start),
        .lut_index  (lut_index),
        .lut_data   (lut_data),
        .wrreg_req  (wrreg_req),
        .rdreg_req  (rdreg_req),
        .addr       (addr),
        .addr_mode  (addr_mode),
        .wrdata     (wrdata),
        .device_id  (device_id),
        .dly_cnt_max(dly_cnt_max),
        .RW_Done    (rw_done | spur_done),
        .ack        (ack | spur_ack),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .nack_cnt   (nack_cnt),
        .nack_flag  (nack_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_ff @(posedge clk) lut_data <= rom[lut_index];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic logic nack_lookup(input logic [15:0] a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < TL; i++)
            if (rom[i][23:8] == a && a != 16'hFFFF && nk_cur[i])
                r = 1'b1;
        return r;
    endfunction

    // Controller model: one write per request, RW_Done after 1..4 cycles
    initial begin
        int          lat;
        bit          aborted;
        logic [15:0] ca;
        logic [7:0]  cd;
        rw_done = 1'b0;
        ack     = 1'b0;
        forever begin
            @(posedge clk); #1;
            while (rst_n && wrreg_req) begin
                ca = addr;
                cd = wrdata;
                log_q.push_back({ca, cd});
                wr_cyc_q.push_back(cyc);
                lat = int'($urandom_range(1, 4));
                aborted = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk); #1;
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (wrreg_req || addr !== ca || wrdata !== cd)
                        hs_err++;
                end
                if (!aborted) begin
                    rw_done = 1'b1;
                    ack     = nack_lookup(ca);
                    done_cyc_q.push_back(cyc);
                end
                @(posedge clk); #1;
                rw_done = 1'b0;
                ack     = 1'b0;
            end
        end
    end

    function automatic vec_t mk(input logic [23:0] a, b, c, d, e, f,
                                input logic [TL-1:0] nk,
                                input logic [7:0] p, r, n);
        vec_t x;
        x.ent      = {f, e, d, c, b, a};
        x.nk       = nk;
        x.wr_plain = p;
        x.wr_retry = r;
        x.nacks    = n;
        return x;
    endfunction

    task automatic load_vec(input int v);
        for (int i = 0; i < TL; i++) rom[i] = vecs[v].ent[i];
        nk_cur = vecs[v].nk;
    endtask

    task automatic clear_logs();
        log_q.delete();
        wr_cyc_q.delete();
        done_cyc_q.delete();
        hs_err = 0;
    endtask

    // Reference: every non-marker entry in order, ATT times if NACKed
    function automatic void build_exp();
        exp_q.delete();
        exp_nack = 0;
        for (int i = 0; i < TL; i++) begin
            if (rom[i][23:8] != 16'hFFFF) begin
                for (int a = 0; a < (nk_cur[i] ? ATT : 1); a++)
                    exp_q.push_back(rom[i]);
                if (nk_cur[i] && exp_nack < 255) exp_nack++;
            end
        end
    endfunction

    task automatic compare_run(input string t);
        build_exp();
        chk({t, "_nwr"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk({t, "_wr"}, 32'(log_q[i]), 32'(exp_q[i]));
        chk({t, "_nack_cnt"}, 32'(nack_cnt), 32'(exp_nack));
        chk({t, "_nack_flag"}, 32'(nack_flag), 32'(exp_nack != 0));
        chk({t, "_done"}, 32'(init_done), 32'd1);
        chk({t, "_busy"}, 32'(init_busy), 32'd0);
        chk({t, "_handshake"}, 32'(hs_err), 32'd0);
    endtask

    task automatic check_reset(input string t);
        chk({t, "_idx"}, 32'(lut_index), 32'd0);
        chk({t, "_req"}, 32'({wrreg_req, rdreg_req}), 32'd0);
        chk({t, "_addr"}, 32'(addr), 32'd0);
        chk({t, "_wrdata"}, 32'(wrdata), 32'd0);
        chk({t, "_flags"}, 32'({init_busy, init_done, nack_flag}), 32'd0);
        chk({t, "_nack_cnt"}, 32'(nack_cnt), 32'd0);
        chk({t, "_consts"}, 32'({addr_mode, device_id}), 32'h178);
        chk({t, "_dly"}, dly_cnt_max, 32'd500);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            ok = init_done;
        end
    endtask

    task automatic wait_wr(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            ok = wrreg_req;
        end
    endtask

    task automatic check_clear(input string t);
        chk({t, "_done_clr"}, 32'(init_done), 32'd0);
        chk({t, "_nack_clr"}, 32'({nack_flag, nack_cnt}), 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int rel;
        int gap;
        rst_n     = 1'b0;
        start     = 1'b0;
        spur_done = 1'b0;
        spur_ack  = 1'b0;
        hs_err    = 0;
        for (int i = 0; i < 1024; i++) rom[i] = '0;

        vecs[0] = mk(24'h300882, 24'hFFFF02, 24'h123456, 24'h4321AB,
                     24'h000100, 24'hFFFF00, 6'b000000, 8'd4, 8'd4, 8'd0);
        vecs[1] = mk(24'h010111, 24'h020222, 24'h030333, 24'h040444,
                     24'h050555, 24'h060666, 6'b000010, 8'd6, 8'd9, 8'd1);
        vecs[2] = mk(24'h0A0010, 24'h0B0120, 24'h0C0230, 24'hFFFF01,
                     24'h0D0440, 24'h0E0550, 6'b100101, 8'd5, 8'd14, 8'd3);

        // Boot: auto-start after reset, power-up wait, delay marker
        load_vec(0);
        clear_logs();
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst_n = 1'b1;
        rel = cyc;
        repeat (10) @(negedge clk);
        chk("pwrup_busy", 32'(init_busy), 32'd1);
        spur_done = 1'b1;
        spur_ack  = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        spur_ack  = 1'b0;
        chk("spur_ignored", 32'({nack_flag, nack_cnt}), 32'd0);
        wait_done(20000, ok);
        chk("boot_finish", 32'(ok), 32'd1);
        compare_run("boot");
        gap = (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - rel : -1;
        chk_rng("boot_pwrup_gap", gap, 1000, 1010);
        gap = (wr_cyc_q.size() > 1 && done_cyc_q.size() > 0)
            ? wr_cyc_q[1] - done_cyc_q[0] : -1;
        chk_rng("marker_2ms_gap", gap, 2000, 2015);

        // Table-driven runs restarted from DONE
        for (int v = 0; v < 3; v++) begin
            load_vec(v);
            clear_logs();
            pulse_start();
            check_clear("tbl");
            wait_done(20000, ok);
            chk("tbl_finish", 32'(ok), 32'd1);
            chk("tbl_writes", 32'(log_q.size()),
                32'((ATT == 4) ? vecs[v].wr_retry : vecs[v].wr_plain));
            chk("tbl_nacks", 32'(nack_cnt), 32'(vecs[v].nacks));
            compare_run("tbl");
        end

        // Start while waiting on the controller must be ignored
        load_vec(1);
        clear_logs();
        pulse_start();
        check_clear("ign");
        wait_wr(3000, ok);
        chk("ign_wr_seen", 32'(ok), 32'd1);
        @(posedge clk);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("ign_busy", 32'(init_busy), 32'd1);
        wait_done(20000, ok);
        chk("ign_finish", 32'(ok), 32'd1);
        compare_run("ign");

        // Reset in the middle of a transfer
        load_vec(2);
        clear_logs();
        pulse_start();
        wait_wr(3000, ok);
        chk("rstw_wr_seen", 32'(ok), 32'd1);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rstw");
        clear_logs();
        rst_n = 1'b1;
        rel = cyc;
        repeat (2) @(negedge clk);
        chk("rstw_busy", 32'(init_busy), 32'd1);
        wait_done(20000, ok);
        chk("rstw_finish", 32'(ok), 32'd1);
        compare_run("rstw");
        gap = (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - rel : -1;
        chk_rng("rstw_pwrup_gap", gap, 1000, 1010);

        // Randomized tables and NACK patterns
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < TL; i++) begin
                if ($urandom_range(0, 3) == 0)
                    rom[i] = {16'hFFFF, 8'($urandom_range(0, 1))};
                else
                    rom[i] = {8'($urandom_range(0, 254)), 8'(i),
                              8'($urandom_range(0, 255))};
                nk_cur[i] = ($urandom_range(0, 3) == 0);
            end
            clear_logs();
            pulse_start();
            check_clear("rnd");
            wait_done(20000, ok);
            chk("rnd_finish", 32'(ok), 32'd1);
            compare_run("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
